// File: rtl/dma_desc_sequencer_pkg.sv
// Shared types and constants for the DMA descriptor sequencer.
//   MEM_ADDR_WIDTH / MEM_DATA_WIDTH : APB address / data widths
//   DMA_REG_*                       : DMA engine register map (byte addresses)
//   dma_desc_t                      : queued transfer descriptor {src, dst, size}
//   seq_state_t                     : sequencer FSM states
//   reg_addr / reg_data             : map of the write-list index to APB address / data
package dma_desc_sequencer_pkg;

  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_DATA_WIDTH = 32;

  localparam logic [MEM_ADDR_WIDTH-1:0] DMA_REG_SRC  = 'h00;
  localparam logic [MEM_ADDR_WIDTH-1:0] DMA_REG_DST  = 'h04;
  localparam logic [MEM_ADDR_WIDTH-1:0] DMA_REG_SIZE = 'h08;
  localparam logic [MEM_ADDR_WIDTH-1:0] DMA_REG_MODE = 'h0C;
  localparam logic [MEM_ADDR_WIDTH-1:0] DMA_REG_INT  = 'h10;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] size;
  } dma_desc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_WAIT_INTR,
    ST_CLR_SETUP,
    ST_CLR_ACCESS,
    ST_WAIT_LOW,
    ST_DONE
  } seq_state_t;

  function automatic logic [MEM_ADDR_WIDTH-1:0] reg_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    reg_addr = DMA_REG_SRC;
      2'd1:    reg_addr = DMA_REG_DST;
      2'd2:    reg_addr = DMA_REG_SIZE;
      default: reg_addr = DMA_REG_MODE;
    endcase
  endfunction

  function automatic logic [MEM_DATA_WIDTH-1:0] reg_data(input logic [1:0] idx,
                                                         input dma_desc_t d);
    case (idx)
      2'd0:    reg_data = d.src;
      2'd1:    reg_data = d.dst;
      2'd2:    reg_data = d.size;
      default: reg_data = MEM_DATA_WIDTH'(1);
    endcase
  endfunction

endpackage

// File: rtl/dma_desc_sequencer_if.sv
// APB write channel plus DMA completion interrupt between the sequencer and the DMA engine.
//   master : sequencer side (drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, receives PREADY/INTR)
//   slave  : DMA engine side
interface dma_desc_sequencer_if;
  import dma_desc_sequencer_pkg::*;

  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [MEM_ADDR_WIDTH-1:0] PADDR;
  logic [MEM_DATA_WIDTH-1:0] PWDATA;
  logic                      PREADY;
  logic                      INTR;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PREADY, INTR);
  modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PREADY, INTR);

endinterface

// File: rtl/dma_desc_sequencer_fifo.sv
// Synchronous descriptor FIFO, DEPTH entries (power of two), async active-low reset.
//   clk, rst_n    : clock / reset
//   push, wdata   : write request and descriptor (ignored when full)
//   pop, rdata    : read request (ignored when empty); rdata shows the head entry
//   full, empty   : occupancy flags
module dma_desc_sequencer_fifo
  import dma_desc_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  dma_desc_t wdata,
  input  logic      pop,
  output dma_desc_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  dma_desc_t       mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_desc_sequencer.sv
// Descriptor-driven APB master for the DMA engine. Queues {src,dst,size} descriptors,
// programs SRC/DST/SIZE/MODE, waits for INTR, clears it via INT, then starts the next job.
//   CLK, RSTN            : clock, async active-low reset
//   desc_valid/ready     : descriptor handshake; desc_src/dst/size descriptor payload
//   apb                  : APB write channel + INTR (master modport)
//   busy                 : job running or descriptors queued
//   job_done/job_err     : one-cycle completion pulse, err = timeout seen during the job
//   jobs_cnt             : completed jobs (wrapping)
module dma_desc_sequencer
  import dma_desc_sequencer_pkg::*;
#(
  parameter int unsigned DESC_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [31:0]           desc_src,
  input  logic [31:0]           desc_dst,
  input  logic [31:0]           desc_size,
  dma_desc_sequencer_if.master  apb,
  output logic                  busy,
  output logic                  job_done,
  output logic                  job_err,
  output logic [15:0]           jobs_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t  state, state_nxt;
  dma_desc_t   cur;
  dma_desc_t   head;
  logic [1:0]  reg_idx;
  logic [TW-1:0] tcnt;
  logic        timeout;
  logic        err;
  logic        ready_en;
  logic        fifo_full, fifo_empty;
  logic        push, pop;
  logic        psel, penable;
  logic [MEM_ADDR_WIDTH-1:0] paddr;
  logic [MEM_DATA_WIDTH-1:0] pwdata;

  assign desc_ready = ready_en && !fifo_full;
  assign push       = desc_valid && desc_ready;
  assign pop        = (state == ST_IDLE) && !fifo_empty;
  assign timeout    = (tcnt == TW'(TIMEOUT_CYCLES));

  dma_desc_sequencer_fifo #(.DEPTH(DESC_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RSTN),
    .push  (push),
    .wdata ('{src: desc_src, dst: desc_dst, size: desc_size}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (!fifo_empty) state_nxt = ST_SETUP;
      ST_SETUP:      state_nxt = ST_ACCESS;
      ST_ACCESS:     if (apb.PREADY) state_nxt = (reg_idx == 2'd3) ? ST_WAIT_INTR : ST_SETUP;
      ST_WAIT_INTR:  if (apb.INTR || timeout) state_nxt = ST_CLR_SETUP;
      ST_CLR_SETUP:  state_nxt = ST_CLR_ACCESS;
      ST_CLR_ACCESS: if (apb.PREADY) state_nxt = ST_WAIT_LOW;
      ST_WAIT_LOW:   if (!apb.INTR || timeout) state_nxt = ST_DONE;
      ST_DONE:       state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs are decoded from state so an asynchronous reset clears them immediately;
  // address/data are zero whenever PSEL is low.
  always_comb begin
    psel    = 1'b0;
    penable = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    case (state)
      ST_SETUP, ST_ACCESS: begin
        psel    = 1'b1;
        penable = (state == ST_ACCESS);
        paddr   = reg_addr(reg_idx);
        pwdata  = reg_data(reg_idx, cur);
      end
      ST_CLR_SETUP, ST_CLR_ACCESS: begin
        psel    = 1'b1;
        penable = (state == ST_CLR_ACCESS);
        paddr   = DMA_REG_INT;
        pwdata  = MEM_DATA_WIDTH'(1);
      end
      default: ;
    endcase
  end

  assign apb.PSEL    = psel;
  assign apb.PENABLE = penable;
  assign apb.PWRITE  = psel;
  assign apb.PADDR   = paddr;
  assign apb.PWDATA  = pwdata;

  assign job_done = (state == ST_DONE);
  assign job_err  = (state == ST_DONE) && err;
  assign busy     = (state != ST_IDLE) || !fifo_empty;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cur      <= '0;
      reg_idx  <= '0;
      tcnt     <= '0;
      err      <= 1'b0;
      jobs_cnt <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (pop) begin
        cur     <= head;
        reg_idx <= '0;
      end
      if (state == ST_ACCESS && apb.PREADY && reg_idx != 2'd3) reg_idx <= reg_idx + 2'd1;
      // Counter only runs in the two wait states and is cleared everywhere else,
      // so it is zero on entry to either wait state.
      if (state == ST_WAIT_INTR || state == ST_WAIT_LOW) begin
        if (!timeout) tcnt <= tcnt + TW'(1);
      end else begin
        tcnt <= '0;
      end
      if ((state == ST_WAIT_INTR && !apb.INTR && timeout) ||
          (state == ST_WAIT_LOW  &&  apb.INTR && timeout))
        err <= 1'b1;
      else if (state == ST_DONE)
        err <= 1'b0;
      if (state == ST_DONE) jobs_cnt <= jobs_cnt + 16'd1;
    end
  end

endmodule
